// File: rtl/tfhe_pbs_job_scheduler.sv
// tfhe_pbs_job_scheduler
// Queues {address, length} PBS job descriptors and launches them one at a time
// on the single PBS engine. Each job ends on a done edge or on a watchdog
// timeout. The engine's read-back {address, length} is then returned as a
// completion record.
//
// Handshakes (valid/ready): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and not yet accepted. Ready may depend on state but never on
// the same-cycle valid. This applies to job_* (host -> queue) and to cpl_*
// (scheduler -> consumer).
module tfhe_pbs_job_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  // descriptor queue
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [DATA_WIDTH-1:0]            job_addr,
  input  logic [DATA_WIDTH-1:0]            job_len,
  input  logic                             flush,
  // PBS engine
  output logic [DATA_WIDTH-1:0]            host_wr_addr,
  output logic [DATA_WIDTH-1:0]            host_wr_len,
  output logic                             start_pbs,
  input  logic                             pbs_busy,
  input  logic                             pbs_done,
  input  logic [DATA_WIDTH-1:0]            host_rd_addr,
  input  logic [DATA_WIDTH-1:0]            host_rd_len,
  // completion records
  output logic                             cpl_valid,
  input  logic                             cpl_ready,
  output logic [DATA_WIDTH-1:0]            cpl_addr,
  output logic [DATA_WIDTH-1:0]            cpl_len,
  output logic                             cpl_timeout,
  // status
  output logic [$clog2(QUEUE_DEPTH):0]     queue_level,
  output logic [31:0]                      jobs_completed,
  output logic [1:0]                       fsm_state
);

  localparam int                PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int                LVL_W     = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(QUEUE_DEPTH);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES != 0);
  // Last watchdog value before a timeout fires; unused when the watchdog is off.
  localparam logic [31:0]       WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  q_addr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  q_len  [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level;
  logic                   done_d;
  logic                   done_event;
  logic [31:0]            wdog;
  logic                   to_flag;
  logic                   push;
  logic                   pop;

  assign job_ready   = (level != FULL_LVL);
  assign queue_level = level;
  assign start_pbs   = (state == ST_LAUNCH);
  assign fsm_state   = state;
  assign done_event  = pbs_done & ~done_d;

  // flush wins over both push and pop so that a flushed queue is really empty
  assign push = job_valid & job_ready & ~flush;
  assign pop  = (state == ST_IDLE) & (level != '0) & ~pbs_busy & ~flush;

  // Descriptor storage; contents are don't-care until written, so no reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) begin
      q_addr[wr_ptr] <= job_addr;
      q_len[wr_ptr]  <= job_len;
    end
  end

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Previous pbs_done, so that a done level left over from an older job is not
  // mistaken for a fresh completion.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      done_d <= 1'b0;
    end else begin
      done_d <= pbs_done;
    end
  end

  // Job sequencer: launch, watch for done or timeout, publish the record.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= ST_IDLE;
      wdog           <= '0;
      to_flag        <= 1'b0;
      host_wr_addr   <= '0;
      host_wr_len    <= '0;
      cpl_valid      <= 1'b0;
      cpl_addr       <= '0;
      cpl_len        <= '0;
      cpl_timeout    <= 1'b0;
      jobs_completed <= '0;
    end else begin
      // consumer took the record; may be re-set below by a reload this cycle
      if (cpl_valid && cpl_ready) begin
        cpl_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            host_wr_addr <= q_addr[rd_ptr];
            host_wr_len  <= q_len[rd_ptr];
            state        <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          // a done edge seen here belongs to no job of ours and is dropped
          wdog  <= '0;
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (done_event) begin
            to_flag <= 1'b0;
            state   <= ST_COMPLETE;
          end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
            to_flag <= 1'b1;
            state   <= ST_COMPLETE;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end

        ST_COMPLETE: begin
          // the output slot is free when empty or being drained this cycle
          if (!cpl_valid || cpl_ready) begin
            cpl_valid      <= 1'b1;
            cpl_addr       <= host_rd_addr;
            cpl_len        <= host_rd_len;
            cpl_timeout    <= to_flag;
            jobs_completed <= jobs_completed + 32'd1;
            state          <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tfhe_pbs_job_scheduler.md
# tfhe_pbs_job_scheduler

Sequences programmable-bootstrapping (PBS) jobs onto the single TFHE PBS engine. Hosts or DMA agents queue {write address, write length} descriptors. The block launches them one at a time when the engine is idle and waits for completion or a watchdog timeout. It then returns the engine's read-back {address, length} as a completion record. It sits between the AXI4-Lite control register block and the PBS engine, replacing direct host pulsing of start_pbs.

## Interface
- DATA_WIDTH, 32, width of all address/length fields
- QUEUE_DEPTH, 4, descriptor FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1_000_000, watchdog limit in RUN; 0 disables the watchdog

- S_AXI_ACLK  in  1  sole clock, rising edge
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
- job_valid  in  1  descriptor offered
- job_ready  out  1  queue can accept (not full)
- job_addr  in  DATA_WIDTH  host write address for job
- job_len  in  DATA_WIDTH  host write length for job
- flush  in  1  one-cycle request to discard all queued (not in-flight) descriptors
- host_wr_addr  out  DATA_WIDTH  address presented to engine for current job
- host_wr_len  out  DATA_WIDTH  length presented to engine for current job
- start_pbs  out  1  one-cycle launch pulse to engine
- pbs_busy  in  1  engine busy level
- pbs_done  in  1  engine done level (held high until next start)
- host_rd_addr  in  DATA_WIDTH  engine result address
- host_rd_len  in  DATA_WIDTH  engine result length
- cpl_valid  out  1  completion record valid
- cpl_ready  in  1  completion consumer ready
- cpl_addr  out  DATA_WIDTH  captured host_rd_addr
- cpl_len  out  DATA_WIDTH  captured host_rd_len
- cpl_timeout  out  1  record closed by watchdog, not by done
- queue_level  out  $clog2(QUEUE_DEPTH)+1  occupied entries
- jobs_completed  out  32  completion records produced, wraps at 2^32

## Operation
- Reset (async, ARESETN=0): state IDLE; queue empty; all outputs 0 (job_ready=1 once reset releases, since it is decoded from an empty queue); done_d=0; counters 0.
- Queue: push on job_valid&job_ready; job_ready = (queue_level != QUEUE_DEPTH). Pointers wrap modulo QUEUE_DEPTH. flush clears the queue in one cycle and overrides any push that cycle. It does not affect the in-flight job.
- done_event = pbs_done & ~done_d, where done_d is pbs_done registered every cycle.
- FSM states:
  - IDLE: if queue non-empty, pbs_busy=0 and flush=0, pop the head and load host_wr_addr/len, then go to LAUNCH. Otherwise stay.
  - LAUNCH: start_pbs=1 (decoded from state), clear watchdog, go to RUN. A done_event in this cycle is ignored.
  - RUN: on done_event go to COMPLETE with timeout flag 0. Otherwise, if TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1, go to COMPLETE with flag 1. Otherwise increment the watchdog. done_event and timeout in the same cycle: done wins.
  - COMPLETE: if !cpl_valid | cpl_ready, load cpl_addr=host_rd_addr, cpl_len=host_rd_len, cpl_timeout=flag, set cpl_valid, increment jobs_completed, go to IDLE. Otherwise hold in COMPLETE.
- cpl_valid clears on cpl_valid&cpl_ready unless reloaded the same cycle. Once asserted, record fields are stable until the handshake.
- host_wr_addr/len hold their value until the next pop.
- Simultaneous push and pop: level unchanged. Push when full is refused.

## Timing
- Descriptor accepted at edge N (queue previously empty, engine idle): pop at edge N+1. start_pbs is high for exactly the cycle following edge N+1, with host_wr_* already valid in that cycle.
- pbs_done rises and is sampled at edge M in RUN: COMPLETE from M+1. cpl_valid high after edge M+2 if the slot is free.
- Back-to-back: the next start_pbs comes no earlier than 2 cycles after the previous record loads, and requires pbs_busy=0.
- Watchdog: timeout record loads TIMEOUT_CYCLES+1 cycles after the start_pbs cycle, assuming cpl_ready=1.
- Output stall: the FSM waits in COMPLETE. Queue pushes continue until full.

## Test plan
- Single job: push {addr=0x1000, len=0x40}; engine asserts done 10 cycles after start with rd={0x2000,0x80} -> one start_pbs pulse, host_wr_*={0x1000,0x40}, record {0x2000,0x80,timeout=0}, jobs_completed=1.
- Fill queue: push 5 descriptors back-to-back with pbs_busy=1 held -> job_ready falls after the 4th push while the first job is still waiting in IDLE (pbs_busy=1), the 5th is held off, queue_level=4. Release busy -> jobs launched in FIFO order.
- Watchdog: TIMEOUT_CYCLES=16, done never rises -> record with cpl_timeout=1 loads 17 cycles after start_pbs; the next queued job launches afterwards.
- Stale done: pbs_done held high across start -> no completion until done falls and rises again.
- Backpressure plus flush: cpl_ready=0 with 2 jobs queued, then flush -> FSM held in COMPLETE, queue_level=0. Raise cpl_ready -> exactly one record, no further start_pbs.
- Async reset mid-RUN -> all outputs 0 immediately, queue_level=0. After release, the scheduler accepts a new job normally.
